// File: rtl/player_ctrl.sv
// Player ship controller: synchronized buttons move the ship each tick; moon contact costs lives.
// Latency: 2 sync cycles plus the next tick edge, outputs registered; no backpressure.
module player_ctrl #(
  parameter int MAX_X       = 384,
  parameter int MAX_Y       = 448,
  parameter int MARGIN      = 8,
  parameter int START_X     = 192,
  parameter int START_Y     = 400,
  parameter int TICK_CYCLES = 4000,
  parameter int HIT_R       = 40,
  parameter int INVUL_TICKS = 120,
  parameter int LIVES_INIT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_slow,
  input  logic [9:0] moon_x,
  input  logic [9:0] moon_y,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [1:0] lives,
  output logic       invul,
  output logic       hit,
  output logic       game_over,
  output logic       tick
);

  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam int INV_W = $clog2(INVUL_TICKS + 1);

  typedef enum logic [1:0] {S_ALIVE, S_INVUL, S_DEAD} state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic slow;
  } btn_t;

  state_t             state, state_nxt;
  btn_t               btn_raw, btn_meta, btn_sync;
  logic [CNT_W-1:0]   tick_cnt;
  logic [INV_W-1:0]   inv_cnt;
  logic signed [10:0] step, mv_x, mv_y;
  logic signed [10:0] dx, dy, adx, ady;
  logic [9:0]         move_x, move_y;
  logic               overlap, take_hit;

  function automatic logic [9:0] clamp(input logic signed [10:0] v, input int lo, input int hi);
    if (int'(v) < lo)      return 10'(lo);
    else if (int'(v) > hi) return 10'(hi);
    else                   return v[9:0];
  endfunction

  assign btn_raw = {btn_up, btn_down, btn_left, btn_right, btn_slow};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
    end
  end

  assign tick = (tick_cnt == CNT_W'(TICK_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CNT_W'(1);
  end

  // Opposing buttons cancel; the clamp keeps the ship off the edges without wrapping.
  always_comb begin
    step = btn_sync.slow ? 11'sd1 : 11'sd2;
    mv_x = '0;
    mv_y = '0;
    if (btn_sync.right && !btn_sync.left)      mv_x = step;
    else if (btn_sync.left && !btn_sync.right) mv_x = -step;
    if (btn_sync.down && !btn_sync.up)         mv_y = step;
    else if (btn_sync.up && !btn_sync.down)    mv_y = -step;
    move_x = clamp($signed({1'b0, player_x}) + mv_x, MARGIN, MAX_X - MARGIN);
    move_y = clamp($signed({1'b0, player_y}) + mv_y, MARGIN, MAX_Y - MARGIN);
  end

  always_comb begin
    dx       = $signed({1'b0, player_x}) - $signed({1'b0, moon_x});
    dy       = $signed({1'b0, player_y}) - $signed({1'b0, moon_y});
    adx      = (dx < 0) ? -dx : dx;
    ady      = (dy < 0) ? -dy : dy;
    overlap  = (int'(adx) < HIT_R) && (int'(ady) < HIT_R);
    take_hit = tick && (state == S_ALIVE) && overlap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_ALIVE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      unique case (state)
        S_ALIVE: if (overlap) state_nxt = (lives == 2'd1) ? S_DEAD : S_INVUL;
        S_INVUL: if (inv_cnt <= INV_W'(1)) state_nxt = S_ALIVE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    invul     = (state == S_INVUL);
    game_over = (state == S_DEAD);
  end

  // A hit on a tick overrides that tick's movement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player_x <= 10'(START_X);
      player_y <= 10'(START_Y);
      lives    <= 2'(LIVES_INIT);
      inv_cnt  <= '0;
      hit      <= 1'b0;
    end else begin
      hit <= take_hit;
      if (tick) begin
        unique case (state)
          S_ALIVE: begin
            if (overlap) begin
              lives <= lives - 2'd1;
              if (lives != 2'd1) begin
                player_x <= 10'(START_X);
                player_y <= 10'(START_Y);
                inv_cnt  <= INV_W'(INVUL_TICKS);
              end
            end else begin
              player_x <= move_x;
              player_y <= move_y;
            end
          end
          S_INVUL: begin
            player_x <= move_x;
            player_y <= move_y;
            inv_cnt  <= inv_cnt - INV_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed and random ticks against a rule-level model, scoreboard-checked.
module tb_player_ctrl;

  localparam int T           = 20;
  localparam int MAX_X       = 384;
  localparam int MAX_Y       = 448;
  localparam int MARGIN      = 8;
  localparam int START_X     = 192;
  localparam int START_Y     = 400;
  localparam int HIT_R       = 40;
  localparam int INVUL_TICKS = 120;
  localparam int LIVES_INIT  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_slow = 1'b0;
  logic [9:0] moon_x = 10'd600, moon_y = 10'd0;
  logic [9:0] player_x, player_y;
  logic [1:0] lives;
  logic       invul, hit, game_over, tick;

  always #5 clk = ~clk;

  player_ctrl #(.TICK_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_slow(btn_slow), .moon_x(moon_x), .moon_y(moon_y),
    .player_x(player_x), .player_y(player_y), .lives(lives), .invul(invul),
    .hit(hit), .game_over(game_over), .tick(tick)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] lives;
    logic       invul;
    logic       hit;
    logic       game_over;
  } obs_t;

  localparam obs_t RST_OBS = '{x: 10'(START_X), y: 10'(START_Y), lives: 2'(LIVES_INIT),
                               invul: 1'b0, hit: 1'b0, game_over: 1'b0};

  obs_t exp_q[$];
  obs_t cur, mon_o, mon_e;
  bit   prev_tick = 1'b0;
  bit   mon_en = 1'b0;
  int   errors = 0, checks = 0;

  // Reference model: ship position, lives, remaining invulnerable ticks, dead flag.
  int m_x, m_y, m_lives, m_inv, m_dead;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_x = START_X; m_y = START_Y; m_lives = LIVES_INIT; m_inv = 0; m_dead = 0;
  endtask

  task automatic model_tick(input bit u, input bit d, input bit l, input bit r, input bit s);
    obs_t o;
    bit   h = 1'b0;
    int   st = s ? 1 : 2;
    int   vx = (r && !l) ? st : (l && !r) ? -st : 0;
    int   vy = (d && !u) ? st : (u && !d) ? -st : 0;
    if (m_dead != 0) begin
    end else if (m_inv > 0) begin
      m_x = clampi(m_x + vx, MARGIN, MAX_X - MARGIN);
      m_y = clampi(m_y + vy, MARGIN, MAX_Y - MARGIN);
      m_inv--;
    end else if (absi(m_x - int'(moon_x)) < HIT_R && absi(m_y - int'(moon_y)) < HIT_R) begin
      h = 1'b1;
      m_lives--;
      if (m_lives == 0) m_dead = 1;
      else begin
        m_x = START_X; m_y = START_Y; m_inv = INVUL_TICKS;
      end
    end else begin
      m_x = clampi(m_x + vx, MARGIN, MAX_X - MARGIN);
      m_y = clampi(m_y + vy, MARGIN, MAX_Y - MARGIN);
    end
    o.x = 10'(m_x); o.y = 10'(m_y); o.lives = 2'(m_lives);
    o.invul = (m_inv > 0) && (m_dead == 0);
    o.hit = h; o.game_over = (m_dead != 0);
    exp_q.push_back(o);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: the cycle after each tick edge must match the next queued expectation;
  // every other cycle must hold the last state with hit low.
  always @(negedge clk) begin
    if (reset) begin
      prev_tick = 1'b0;
      cur = RST_OBS;
    end else if (mon_en) begin
      mon_o = {player_x, player_y, lives, invul, hit, game_over};
      checks++;
      if (prev_tick) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL post_tick: output without a queued expectation");
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_o !== mon_e) begin
            errors++;
            $display("FAIL post_tick: got x=%0d y=%0d lives=%0d invul=%0b hit=%0b go=%0b want x=%0d y=%0d lives=%0d invul=%0b hit=%0b go=%0b",
                     mon_o.x, mon_o.y, mon_o.lives, mon_o.invul, mon_o.hit, mon_o.game_over,
                     mon_e.x, mon_e.y, mon_e.lives, mon_e.invul, mon_e.hit, mon_e.game_over);
          end
          cur = mon_e;
          cur.hit = 1'b0;
        end
      end else if (mon_o !== cur) begin
        errors++;
        $display("FAIL steady: got x=%0d y=%0d lives=%0d invul=%0b hit=%0b go=%0b want x=%0d y=%0d lives=%0d invul=%0b hit=%0b go=%0b",
                 mon_o.x, mon_o.y, mon_o.lives, mon_o.invul, mon_o.hit, mon_o.game_over,
                 cur.x, cur.y, cur.lives, cur.invul, cur.hit, cur.game_over);
      end
      prev_tick = tick;
    end
  end

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Returns just after the tick edge; n is the number of negedges waited.
  task automatic wait_tick(output int n);
    bit found = 1'b0;
    n = 0;
    while (!found && n < 3 * T) begin
      @(negedge clk);
      n++;
      if (tick) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no tick within %0d cycles", 3 * T);
      finish_run();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input bit u, input bit d, input bit l, input bit r, input bit s, output int n);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_slow = s;
    model_tick(u, d, l, r, s);
    wait_tick(n);
  endtask

  task automatic run_ticks(input int cnt, input bit u, input bit d, input bit l, input bit r, input bit s);
    int n;
    for (int i = 0; i < cnt; i++) do_tick(u, d, l, r, s, n);
  endtask

  // Right-button pulse of len cycles ending at the tick edge; eff is whether it should count.
  task automatic pulse_tick(input int len, input bit eff);
    int n;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_slow = 0;
    model_tick(1'b0, 1'b0, 1'b0, eff, 1'b0);
    repeat (T - len) @(posedge clk);
    #1 btn_right = 1'b1;
    wait_tick(n);
    btn_right = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_x", player_x, START_X);
    chk("rst_y", player_y, START_Y);
    chk("rst_lives", lives, LIVES_INIT);
    chk("rst_invul", invul, 0);
    chk("rst_hit", hit, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_tick", tick, 0);
    model_reset();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_slow = 0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    int n;
    int mx, my;
    apply_reset();

    do_tick(0, 0, 0, 1, 0, n);
    chk("first_tick_delay", n, T - 1);
    run_ticks(9, 0, 0, 0, 1, 0);
    chk("right10_x", player_x, 212);
    chk("right10_y", player_y, 400);
    run_ticks(4, 0, 0, 0, 1, 1);
    chk("slow4_x", player_x, 216);
    run_ticks(10, 0, 0, 1, 1, 0);
    chk("left_right_x", player_x, 216);
    run_ticks(200, 0, 0, 1, 0, 0);
    chk("clamp_left_x", player_x, 8);
    run_ticks(200, 1, 0, 0, 0, 0);
    chk("clamp_up_y", player_y, 8);
    pulse_tick(1, 1'b0);
    chk("pulse1_x", player_x, 8);
    pulse_tick(3, 1'b1);
    chk("pulse3_x", player_x, 10);

    apply_reset();
    moon_x = 10'd152; moon_y = 10'd400;
    run_ticks(3, 0, 0, 0, 0, 0);
    chk("dx40_lives", lives, 3);
    moon_x = 10'd153;
    run_ticks(1, 0, 0, 0, 0, 0);
    chk("dx39_hit", hit, 1);
    chk("dx39_lives", lives, 2);
    chk("dx39_invul", invul, 1);
    moon_x = 10'd192; moon_y = 10'd380;
    run_ticks(120, 0, 0, 0, 0, 0);
    chk("invul_expiry_lives", lives, 2);
    chk("invul_expiry_flag", invul, 0);
    run_ticks(1, 0, 0, 0, 0, 0);
    chk("second_hit", hit, 1);
    chk("second_hit_lives", lives, 1);
    chk("second_hit_y", player_y, 400);
    run_ticks(5, 1, 0, 0, 0, 0);
    run_ticks(115, 0, 0, 0, 0, 0);
    run_ticks(1, 0, 0, 0, 0, 0);
    chk("third_hit_lives", lives, 0);
    chk("third_hit_game_over", game_over, 1);
    chk("third_hit_hold_y", player_y, 390);
    run_ticks(50, 0, 0, 0, 1, 0);
    chk("dead_frozen_x", player_x, 192);
    chk("dead_frozen_y", player_y, 390);
    repeat (7) @(posedge clk);
    apply_reset();

    moon_x = 10'd600; moon_y = 10'd0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mx = clampi(m_x + int'($urandom_range(0, 100)) - 50, 0, 1023);
        my = clampi(m_y + int'($urandom_range(0, 100)) - 50, 0, 1023);
      end else begin
        mx = int'($urandom_range(0, 1023));
        my = int'($urandom_range(0, 1023));
      end
      moon_x = 10'(mx); moon_y = 10'(my);
      do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);
      if (m_dead != 0 && $urandom_range(0, 4) == 0) apply_reset();
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    finish_run();
  end

endmodule
